// File: rtl/axis_data_chk_if.sv
// AXI-Stream receive bus for the data checker: payload, byte enables, markers and ready.
interface axis_data_chk_if #(
  parameter int unsigned DATA_WIDTH = 1024
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tuser;
  logic                    tlast;
  logic                    tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_data_chk.sv
// AXI-Stream sink that checks an incrementing 64-bit word sequence, packet lengths,
// tuser and tkeep, with optional periodic backpressure and saturating event counters.
module axis_data_chk #(
  parameter int unsigned G_AXIS_DATA_WIDTH = 1024
) (
  input  logic                  axis_streaming_data_clk,
  input  logic                  axis_streaming_arst,
  input  logic                  axis_data_chk_enable,
  input  logic                  chk_clear,
  input  logic [15:0]           pkt_length,
  input  logic [7:0]            throttle_period,
  axis_data_chk_if.slave        axis_streaming_data_rx,
  output logic [31:0]           pkt_count,
  output logic [31:0]           err_len_count,
  output logic [31:0]           err_data_count,
  output logic [31:0]           err_user_count,
  output logic [31:0]           err_keep_count,
  output logic                  chk_error,
  output logic                  chk_in_pkt
);

  localparam int unsigned KeepWidth = G_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StInPkt, StOverrun} state_e;

  state_e         state_q, state_d;
  logic [15:0]    beat_cnt_q, beat_cnt_d;
  logic [15:0]    len_q, len_d;
  logic [63:0]    exp_q, exp_d;
  logic [31:0]    pkt_cnt_q, len_err_q, data_err_q, user_err_q, keep_err_q;
  logic           chk_error_q;
  logic [7:0]     thr_cnt_q;
  logic           tready_q;

  logic           accept;
  logic           throttle_slot;
  logic [15:0]    eff_len;
  logic [15:0]    n_beat;
  logic [63:0]    rx_word;
  logic [KeepWidth-1:0] keep_w;
  logic           inc_pkt, inc_len, inc_data, inc_user, inc_keep;

  assign rx_word = axis_streaming_data_rx.tdata[63:0];
  assign keep_w  = axis_streaming_data_rx.tkeep;
  assign accept  = axis_streaming_data_rx.tvalid & tready_q;
  assign eff_len = (pkt_length == 16'd0) ? 16'd1 : pkt_length;
  assign n_beat  = beat_cnt_q + 16'd1;

  assign throttle_slot = (throttle_period != 8'd0) && (thr_cnt_q == throttle_period - 8'd1);

  assign axis_streaming_data_rx.tready = tready_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Free-running throttle counter and registered ready.
  always_ff @(posedge axis_streaming_data_clk or posedge axis_streaming_arst) begin
    if (axis_streaming_arst) begin
      thr_cnt_q <= 8'd0;
      tready_q  <= 1'b0;
    end else begin
      if (throttle_period == 8'd0 || thr_cnt_q >= throttle_period - 8'd1) begin
        thr_cnt_q <= 8'd0;
      end else begin
        thr_cnt_q <= thr_cnt_q + 8'd1;
      end
      tready_q <= axis_data_chk_enable & ~throttle_slot;
    end
  end

  // Next-state logic: packet FSM, word tracking and per-beat error events.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    exp_d      = exp_q;
    inc_pkt    = 1'b0;
    inc_len    = 1'b0;
    inc_data   = 1'b0;
    inc_user   = 1'b0;
    inc_keep   = 1'b0;
    if (accept) begin
      inc_user = axis_streaming_data_rx.tuser;
      inc_keep = ~&keep_w;
      inc_data = (rx_word != exp_q);
      // Equals exp_q + 1 on a match and resyncs on a mismatch.
      exp_d    = rx_word + 64'd1;
      unique case (state_q)
        StIdle: begin
          len_d = eff_len;
          if (axis_streaming_data_rx.tlast) begin
            inc_pkt = (eff_len == 16'd1);
            inc_len = (eff_len != 16'd1);
          end else begin
            beat_cnt_d = 16'd1;
            state_d    = StInPkt;
          end
        end
        StInPkt: begin
          if (axis_streaming_data_rx.tlast) begin
            inc_pkt    = (n_beat == len_q);
            inc_len    = (n_beat != len_q);
            beat_cnt_d = 16'd0;
            state_d    = StIdle;
          end else if (n_beat == len_q) begin
            beat_cnt_d = 16'd0;
            state_d    = StOverrun;
          end else begin
            beat_cnt_d = n_beat;
          end
        end
        StOverrun: begin
          if (axis_streaming_data_rx.tlast) begin
            inc_len = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Checker state and saturating counters; clear outranks a same-cycle beat.
  always_ff @(posedge axis_streaming_data_clk or posedge axis_streaming_arst) begin
    if (axis_streaming_arst) begin
      state_q     <= StIdle;
      beat_cnt_q  <= 16'd0;
      len_q       <= 16'd1;
      exp_q       <= 64'd0;
      pkt_cnt_q   <= 32'd0;
      len_err_q   <= 32'd0;
      data_err_q  <= 32'd0;
      user_err_q  <= 32'd0;
      keep_err_q  <= 32'd0;
      chk_error_q <= 1'b0;
    end else if (chk_clear) begin
      state_q     <= StIdle;
      beat_cnt_q  <= 16'd0;
      len_q       <= 16'd1;
      exp_q       <= 64'd0;
      pkt_cnt_q   <= 32'd0;
      len_err_q   <= 32'd0;
      data_err_q  <= 32'd0;
      user_err_q  <= 32'd0;
      keep_err_q  <= 32'd0;
      chk_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      exp_q      <= exp_d;
      if (inc_pkt)  pkt_cnt_q  <= sat_inc(pkt_cnt_q);
      if (inc_len)  len_err_q  <= sat_inc(len_err_q);
      if (inc_data) data_err_q <= sat_inc(data_err_q);
      if (inc_user) user_err_q <= sat_inc(user_err_q);
      if (inc_keep) keep_err_q <= sat_inc(keep_err_q);
      if (inc_len | inc_data | inc_user | inc_keep) chk_error_q <= 1'b1;
    end
  end

  assign pkt_count      = pkt_cnt_q;
  assign err_len_count  = len_err_q;
  assign err_data_count = data_err_q;
  assign err_user_count = user_err_q;
  assign err_keep_count = keep_err_q;
  assign chk_error      = chk_error_q;
  assign chk_in_pkt     = (state_q == StInPkt) || (state_q == StOverrun);

endmodule

// File: tb/tb_axis_data_chk.sv
// Directed bench for axis_data_chk: sequence, length, throttle, enable, clear and reset cases.
module tb_axis_data_chk;

  localparam int unsigned W = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] plen = 16'd4;
  logic [7:0]  thr = 8'd0;
  logic [31:0] pkt_count, err_len_count, err_data_count, err_user_count, err_keep_count;
  logic        chk_error, chk_in_pkt;

  int n_checks = 0;
  int n_pass   = 0;
  int stalls   = 0;

  // throttle scenario bookkeeping
  int          n_acc, first_c, last_c, lows;
  logic        acc;
  logic [63:0] w;

  axis_data_chk_if #(.DATA_WIDTH(W)) rx ();

  axis_data_chk #(.G_AXIS_DATA_WIDTH(W)) dut (
    .axis_streaming_data_clk (clk),
    .axis_streaming_arst     (rst),
    .axis_data_chk_enable    (en),
    .chk_clear               (clr),
    .pkt_length              (plen),
    .throttle_period         (thr),
    .axis_streaming_data_rx  (rx),
    .pkt_count               (pkt_count),
    .err_len_count           (err_len_count),
    .err_data_count          (err_data_count),
    .err_user_count          (err_user_count),
    .err_keep_count          (err_keep_count),
    .chk_error               (chk_error),
    .chk_in_pkt              (chk_in_pkt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_counts(input string tag, input int p, input int l, input int d,
                              input int u, input int k);
    check({tag, "_pkt"},  64'(pkt_count),      64'(p));
    check({tag, "_len"},  64'(err_len_count),  64'(l));
    check({tag, "_data"}, 64'(err_data_count), 64'(d));
    check({tag, "_user"}, 64'(err_user_count), 64'(u));
    check({tag, "_keep"}, 64'(err_keep_count), 64'(k));
  endtask

  // Present one beat and hold it until accepted (bounded); returns #1 after the accepting edge.
  task automatic send_beat(input logic [63:0] word, input logic last, input logic user,
                           input logic keep_ok);
    logic got;
    got = 1'b0;
    rx.tdata  = {~word, word};
    rx.tlast  = last;
    rx.tuser  = user;
    rx.tkeep  = keep_ok ? {(W/8){1'b1}} : ~16'h0001;
    rx.tvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rx.tready) got = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    rx.tvalid = 1'b0;
    if (!got) check("beat_accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    rx.tdata  = '0;
    rx.tkeep  = '0;
    rx.tvalid = 1'b0;
    rx.tuser  = 1'b0;
    rx.tlast  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 64'(rx.tready), 64'd0);
    check("rst_in_pkt", 64'(chk_in_pkt), 64'd0);
    check("rst_error", 64'(chk_error), 64'd0);
    check_counts("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(rx.tready), 64'd1);

    // Three good 4-beat packets, words 0..11, no stalls expected
    stalls = 0;
    for (int i = 0; i < 12; i++) send_beat(64'(i), (i % 4) == 3, 1'b0, 1'b1);
    check_counts("good3", 3, 0, 0, 0, 0);
    check("good3_stalls", 64'(stalls), 64'd0);
    check("good3_error", 64'(chk_error), 64'd0);

    // Short (3) and long (6) packets
    pulse_clear();
    for (int i = 0; i < 3; i++) send_beat(64'(i), i == 2, 1'b0, 1'b1);
    check("short_len", 64'(err_len_count), 64'd1);
    check("short_in_pkt", 64'(chk_in_pkt), 64'd0);
    for (int i = 3; i < 7; i++) send_beat(64'(i), 1'b0, 1'b0, 1'b1);
    check("overrun_in_pkt", 64'(chk_in_pkt), 64'd1);
    send_beat(64'd7, 1'b0, 1'b0, 1'b1);
    check("overrun_in_pkt2", 64'(chk_in_pkt), 64'd1);
    check("overrun_no_count", 64'(err_len_count), 64'd1);
    send_beat(64'd8, 1'b1, 1'b0, 1'b1);
    check_counts("lenerr", 0, 2, 0, 0, 0);
    check("lenerr_in_pkt", 64'(chk_in_pkt), 64'd0);
    check("lenerr_sticky", 64'(chk_error), 64'd1);

    // Clear returns everything to zero
    pulse_clear();
    check_counts("clr", 0, 0, 0, 0, 0);
    check("clr_error", 64'(chk_error), 64'd0);

    // Data resync: 0,1,7,8
    send_beat(64'd0, 1'b0, 1'b0, 1'b1);
    send_beat(64'd1, 1'b0, 1'b0, 1'b1);
    send_beat(64'd7, 1'b0, 1'b0, 1'b1);
    send_beat(64'd8, 1'b1, 1'b0, 1'b1);
    check_counts("resync", 1, 0, 1, 0, 0);
    // Single-beat packet with tuser and a partial tkeep: both counted in the same beat
    plen = 16'd1;
    send_beat(64'd9, 1'b1, 1'b1, 1'b0);
    check_counts("user_keep", 2, 0, 1, 1, 1);
    // Length 0 behaves as 1
    plen = 16'd0;
    send_beat(64'd10, 1'b1, 1'b0, 1'b1);
    check("len0", 64'(pkt_count), 64'd3);
    // pkt_length changed mid-packet is ignored until the next packet
    plen = 16'd4;
    send_beat(64'd11, 1'b0, 1'b0, 1'b1);
    send_beat(64'd12, 1'b0, 1'b0, 1'b1);
    plen = 16'd2;
    send_beat(64'd13, 1'b0, 1'b0, 1'b1);
    send_beat(64'd14, 1'b1, 1'b0, 1'b1);
    check_counts("len_sample", 4, 0, 1, 1, 1);
    plen = 16'd4;

    // Throttle 4 with an always-valid source: 16 beats span 21 cycles, 5 ready-low cycles
    pulse_clear();
    thr = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    n_acc = 0; first_c = 0; last_c = 0; lows = 0; w = 64'd0;
    rx.tdata = {~w, w}; rx.tlast = 1'b0; rx.tuser = 1'b0; rx.tkeep = '1; rx.tvalid = 1'b1;
    for (int c = 0; c < 60 && n_acc < 16; c++) begin
      @(negedge clk);
      acc = rx.tready;
      if (acc) begin
        if (n_acc == 0) first_c = c;
        last_c = c;
      end else if (n_acc > 0) begin
        lows++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        w = 64'(n_acc);
        rx.tdata = {~w, w};
        rx.tlast = (n_acc % 4) == 3;
      end
    end
    rx.tvalid = 1'b0;
    check("thr_beats", 64'(n_acc), 64'd16);
    check("thr_span", 64'(last_c - first_c + 1), 64'd21);
    check("thr_lows", 64'(lows), 64'd5);
    check_counts("thr", 4, 0, 0, 0, 0);
    thr = 8'd0;
    repeat (2) @(posedge clk);
    #1;

    // Enable gap mid-packet
    pulse_clear();
    send_beat(64'd0, 1'b0, 1'b0, 1'b1);
    send_beat(64'd1, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    lows = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!rx.tready) lows++;
      @(posedge clk);
      #1;
    end
    check("gap_lows", 64'(lows), 64'd4);
    check("gap_in_pkt", 64'(chk_in_pkt), 64'd1);
    en = 1'b1;
    send_beat(64'd2, 1'b0, 1'b0, 1'b1);
    send_beat(64'd3, 1'b1, 1'b0, 1'b1);
    check_counts("gap", 1, 0, 0, 0, 0);

    // Clear in the same cycle as an accepted (faulty) beat
    rx.tdata = {~64'd99, 64'd99}; rx.tlast = 1'b1; rx.tuser = 1'b1; rx.tkeep = '0;
    rx.tvalid = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    check("clrbeat_ready", 64'(rx.tready), 64'd1);
    @(posedge clk);
    #1;
    clr = 1'b0;
    rx.tvalid = 1'b0;
    check_counts("clrbeat", 0, 0, 0, 0, 0);
    check("clrbeat_error", 64'(chk_error), 64'd0);
    check("clrbeat_in_pkt", 64'(chk_in_pkt), 64'd0);
    plen = 16'd1;
    send_beat(64'd0, 1'b1, 1'b0, 1'b1);
    check_counts("after_clrbeat", 1, 0, 0, 0, 0);

    // Reset mid-packet, then a clean packet from word 0
    plen = 16'd4;
    send_beat(64'd1, 1'b0, 1'b0, 1'b1);
    send_beat(64'd2, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_in_pkt", 64'(chk_in_pkt), 64'd0);
    check("arst_tready", 64'(rx.tready), 64'd0);
    check("arst_pkt", 64'(pkt_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(64'(i), i == 3, 1'b0, 1'b1);
    check_counts("post_rst", 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
